// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the rx and tx/echo paths
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchroniser for a single asynchronous bit
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte valid/ready holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int div_ratio = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(div_ratio);
    localparam logic [CW-1:0] HALF_LAST = CW'(div_ratio / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(div_ratio - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 byte_done;

    bit_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame FSM: start-edge detect, mid-bit sampling, stop-bit check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_prev   <= 1'b1;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, so a stuck-low line never retriggers
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is never missed
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            byte_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register: accept a completed byte unless an unconsumed one is still held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;

    uart_rx #(.div_ratio(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame whose start bit begins after edge c0 has its stop bit
    // judged at edge c0 + 3 + 9.5 bit times; a good byte reaches the holding reg one edge later.
    typedef struct {
        int         sample_at;
        logic [7:0] b;
        bit         ok;
    } frame_t;

    frame_t     fq[$];
    int         cyc = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_b = 8'h00;
    int         pend_at = 0;
    int         last_start = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
                m_ferr  = 1'b0;
                m_ovr   = 1'b0;
                pend    = 1'b0;
                fq.delete();
            end else begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                if (pend && pend_at == cyc) begin
                    if (!m_valid || ready) begin
                        m_data  = pend_b;
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    pend = 1'b0;
                end else if (m_valid && ready) begin
                    m_valid = 1'b0;
                end
                if (fq.size() > 0 && fq[0].sample_at == cyc) begin
                    if (fq[0].ok) begin
                        pend    = 1'b1;
                        pend_b  = fq[0].b;
                        pend_at = cyc + 1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    void'(fq.pop_front());
                end
            end
        end
    end

    int         n_ferr = 0;
    int         n_ovr = 0;
    logic [7:0] hs_q[$];

    // Per-cycle comparison against the model, plus event logging
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                check("valid", {31'd0, valid}, {31'd0, m_valid});
                check("data", {24'd0, data}, {24'd0, m_data});
                check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
                check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
                if (valid && ready) hs_q.push_back(data);
                if (frame_err) n_ferr++;
                if (overrun) n_ovr++;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_ferr = 0;
        n_ovr = 0;
        hs_q.delete();
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    // Must be called at posedge+1; leaves the line high at posedge+1
    task automatic send_frame(input logic [7:0] b, input bit stop, input int low_bits);
        last_start = cyc;
        fq.push_back('{cyc + 3 + (19 * DIV) / 2, b, stop});
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        for (int i = 0; i < low_bits; i++) bit_out(1'b0);
        rx = 1'b1;
    endtask

    initial begin
        int k;
        int lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: single byte with ready high, latency pinned
        ready = 1'b1;
        clear_log();
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                k = 0;
                #1;
                while (!valid && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                lat = cyc - last_start;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("t1_latency", lat, 32'd156);
        check("t1_hs_count", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check("t1_byte", {24'd0, hs_q[0]}, 32'h0000_00A5);
        check("t1_ferr", n_ferr, 32'd0);
        check("t1_ovr", n_ovr, 32'd0);
        check("t1_valid_low", {31'd0, valid}, 32'd0);

        // 2: back-to-back with ready low -> one overrun, first byte held
        ready = 1'b0;
        clear_log();
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'h7E, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t2_ovr", n_ovr, 32'd1);
        check("t2_data", {24'd0, data}, 32'h0000_003C);
        check("t2_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_valid_drop", {31'd0, valid}, 32'd0);
        check("t2_hs", hs_q.size(), 32'd1);

        // 3: stop bit forced low, line held low five more bits
        clear_log();
        send_frame(8'h55, 1'b0, 5);
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("t3_ferr", n_ferr, 32'd1);
        check("t3_hs", hs_q.size(), 32'd0);
        check("t3_valid", {31'd0, valid}, 32'd0);

        // 4: short glitch shorter than half a bit
        clear_log();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (12 * DIV) @(posedge clk);
        #1;
        check("t4_hs", hs_q.size(), 32'd0);
        check("t4_ferr", n_ferr, 32'd0);

        // 5: reset in the middle of data bit 4 of 0xFF, then 0x01
        clear_log();
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                repeat (83) @(posedge clk);
                #1;
                rst = 1'b0;
                #1;
                check("t5_rst_valid", {31'd0, valid}, 32'd0);
                check("t5_rst_data", {24'd0, data}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
                rst = 1'b1;
            end
        join
        repeat (DIV) @(posedge clk);
        #1;
        send_frame(8'h01, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_hs", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check("t5_byte", {24'd0, hs_q[0]}, 32'h0000_0001);
        check("t5_ferr", n_ferr, 32'd0);

        // 6: ready held high, 0x00 and 0xFF back-to-back
        clear_log();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_hs", hs_q.size(), 32'd2);
        if (hs_q.size() > 1) begin
            check("t6_byte0", {24'd0, hs_q[0]}, 32'h0000_0000);
            check("t6_byte1", {24'd0, hs_q[1]}, 32'h0000_00FF);
        end
        check("t6_ovr", n_ovr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
